// File: rtl/hnf_mshr_excl_monitor_lru_pkg.sv
// Shared widths, CHI-E request opcodes and opcode-class helpers for the HN-F exclusive monitor.
package hnf_mshr_excl_monitor_lru_pkg;

  localparam int SRCID_W  = 11;
  localparam int OPCODE_W = 7;
  localparam int ADDR_W   = 52;
  localparam int NS_W     = 1;
  localparam int LPID_W   = 5;
  localparam int EXCL_W   = 1;

  localparam logic [OPCODE_W-1:0] OP_READ_CLEAN       = 7'h02;
  localparam logic [OPCODE_W-1:0] OP_READ_NO_SNP      = 7'h04;
  localparam logic [OPCODE_W-1:0] OP_CLEAN_UNIQUE     = 7'h0B;
  localparam logic [OPCODE_W-1:0] OP_MAKE_UNIQUE      = 7'h0C;
  localparam logic [OPCODE_W-1:0] OP_WRITE_CLEAN_FULL = 7'h17;
  localparam logic [OPCODE_W-1:0] OP_WRITE_UNIQ_PTL   = 7'h18;
  localparam logic [OPCODE_W-1:0] OP_WRITE_UNIQ_FULL  = 7'h19;
  localparam logic [OPCODE_W-1:0] OP_WRITE_BACK_PTL   = 7'h1A;
  localparam logic [OPCODE_W-1:0] OP_WRITE_BACK_FULL  = 7'h1B;
  localparam logic [OPCODE_W-1:0] OP_WRITE_NOSNP_PTL  = 7'h1C;
  localparam logic [OPCODE_W-1:0] OP_WRITE_NOSNP_FULL = 7'h1D;
  localparam logic [OPCODE_W-1:0] OP_READ_NSD         = 7'h26;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_XLD,
    REQ_XST,
    REQ_NXW
  } req_class_e;

  function automatic logic is_xld_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_READ_NO_SNP) || (op == OP_READ_NSD) || (op == OP_READ_CLEAN);
  endfunction

  function automatic logic is_xst_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_WRITE_NOSNP_FULL) || (op == OP_WRITE_NOSNP_PTL) || (op == OP_CLEAN_UNIQUE);
  endfunction

  function automatic logic is_nxw_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_WRITE_NOSNP_FULL) || (op == OP_WRITE_NOSNP_PTL) ||
           (op == OP_WRITE_UNIQ_FULL)  || (op == OP_WRITE_UNIQ_PTL)  ||
           (op == OP_WRITE_BACK_FULL)  || (op == OP_WRITE_BACK_PTL)  ||
           (op == OP_WRITE_CLEAN_FULL) || (op == OP_MAKE_UNIQUE);
  endfunction

  function automatic req_class_e classify(input logic req, input logic excl,
                                          input logic [OPCODE_W-1:0] op);
    if (!req)                          return REQ_NONE;
    else if (excl && is_xld_op(op))    return REQ_XLD;
    else if (excl && is_xst_op(op))    return REQ_XST;
    else if (!excl && is_nxw_op(op))   return REQ_NXW;
    else                               return REQ_NONE;
  endfunction

endpackage

// File: rtl/hnf_mshr_excl_monitor_lru_age.sv
// Per-entry LRU rank registers: touch/allocate update, victim (oldest) index and full flag.
module hnf_mshr_excl_monitor_lru_age
  import hnf_mshr_excl_monitor_lru_pkg::*;
#(
  parameter int N     = 16,
  parameter int AGE_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     valid_i,
  input  logic             upd_en_i,
  input  logic             upd_alloc_i,
  input  logic [AGE_W-1:0] upd_idx_i,
  output logic [AGE_W-1:0] victim_idx_o,
  output logic             full_o
);

  logic [AGE_W-1:0] age_q [N];
  logic [AGE_W-1:0] age_d [N];
  logic [N-1:0]     used;
  logic [AGE_W-1:0] gap;
  logic [AGE_W-1:0] thr;

  // Ranks occupied by valid entries; the lowest unused rank bounds the shift on allocation,
  // which keeps ranks unique even when invalidations have left gaps.
  always_comb begin
    used = '0;
    for (int v = 0; v < N; v++) begin
      for (int j = 0; j < N; j++) begin
        if (valid_i[j] && (age_q[j] == AGE_W'(v))) used[v] = 1'b1;
      end
    end
    gap = '0;
    for (int v = N - 1; v >= 0; v--) begin
      if (!used[v]) gap = AGE_W'(v);
    end
  end

  always_comb begin
    thr = upd_alloc_i ? gap : age_q[upd_idx_i];
    for (int j = 0; j < N; j++) begin
      age_d[j] = age_q[j];
      if (upd_en_i) begin
        if (upd_idx_i == AGE_W'(j)) age_d[j] = '0;
        else if (valid_i[j] && (age_q[j] < thr)) age_d[j] = age_q[j] + 1'b1;
      end
    end
  end

  always_comb begin
    victim_idx_o = '0;
    for (int j = 0; j < N; j++) begin
      if (valid_i[j] && (age_q[j] == AGE_W'(N - 1))) victim_idx_o = AGE_W'(j);
    end
    full_o = &valid_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N; j++) age_q[j] <= '0;
    end else begin
      for (int j = 0; j < N; j++) age_q[j] <= age_d[j];
    end
  end

endmodule

// File: rtl/hnf_mshr_excl_monitor_lru.sv
// HN-F global exclusive monitor: one (addr granule, NS) reservation per (SrcID, LPID),
// LRU replacement on overflow, registered s1 pass/fail/evict pulses and occupancy.
module hnf_mshr_excl_monitor_lru
  import hnf_mshr_excl_monitor_lru_pkg::*;
#(
  parameter int EXCL_ENTRY_NUM = 16,
  parameter int GRANULE_OFFSET = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  mshr_alloc_en_s0,
  input  logic                                  li_mshr_rxreq_valid_s0,
  input  logic [SRCID_W-1:0]                    li_mshr_rxreq_srcid_s0,
  input  logic [OPCODE_W-1:0]                   li_mshr_rxreq_opcode_s0,
  input  logic [ADDR_W-1:0]                     li_mshr_rxreq_addr_s0,
  input  logic [NS_W-1:0]                       li_mshr_rxreq_ns_s0,
  input  logic [LPID_W-1:0]                     li_mshr_rxreq_lpid_s0,
  input  logic [EXCL_W-1:0]                     li_mshr_rxreq_excl_s0,
  input  logic                                  excl_flush_i,
  output logic                                  excl_pass_s1,
  output logic                                  excl_fail_s1,
  output logic                                  excl_evict_s1,
  output logic [$clog2(EXCL_ENTRY_NUM+1)-1:0]   excl_occupancy
);

  localparam int N      = EXCL_ENTRY_NUM;
  localparam int AGE_W  = $clog2(N);
  localparam int IDX_W  = AGE_W;
  localparam int OCC_W  = $clog2(N + 1);
  localparam int GADDR_W = ADDR_W - GRANULE_OFFSET;

  logic [N-1:0]         valid_q, valid_d;
  logic [SRCID_W-1:0]   srcid_q [N];
  logic [LPID_W-1:0]    lpid_q  [N];
  logic [GADDR_W-1:0]   gaddr_q [N];
  logic [NS_W-1:0]      ns_q    [N];

  logic                 pass_d, fail_d, evict_d;
  logic                 pass_q, fail_q, evict_q;
  logic [OCC_W-1:0]     occ_d, occ_q;

  logic                 req;
  req_class_e           req_cls;
  logic                 is_cu;
  logic [GADDR_W-1:0]   req_gaddr;
  logic [N-1:0]         lp_hit, am_hit;
  logic                 lp_any, st_hit;
  logic [IDX_W-1:0]     lp_idx, free_idx;
  logic [IDX_W-1:0]     victim_idx;
  logic                 full;
  logic                 arm;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  logic                 upd_en, upd_alloc;
  logic                 unused_addr_lsb;

  assign unused_addr_lsb = ^li_mshr_rxreq_addr_s0[GRANULE_OFFSET-1:0];

  assign req       = li_mshr_rxreq_valid_s0 & mshr_alloc_en_s0;
  assign req_cls   = classify(req, li_mshr_rxreq_excl_s0[0], li_mshr_rxreq_opcode_s0);
  assign is_cu     = (li_mshr_rxreq_opcode_s0 == OP_CLEAN_UNIQUE);
  assign req_gaddr = li_mshr_rxreq_addr_s0[ADDR_W-1:GRANULE_OFFSET];

  always_comb begin
    lp_idx   = '0;
    free_idx = '0;
    for (int i = 0; i < N; i++) begin
      lp_hit[i] = valid_q[i] && (srcid_q[i] == li_mshr_rxreq_srcid_s0) &&
                  (lpid_q[i] == li_mshr_rxreq_lpid_s0);
      am_hit[i] = valid_q[i] && (gaddr_q[i] == req_gaddr) && (ns_q[i] == li_mshr_rxreq_ns_s0);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (lp_hit[i])   lp_idx   = IDX_W'(i);
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
    lp_any = |lp_hit;
    st_hit = |(lp_hit & am_hit);
  end

  // Flush wins over everything: exclusive loads still pass and stores fail, but nothing is recorded.
  always_comb begin
    valid_d   = valid_q;
    pass_d    = 1'b0;
    fail_d    = 1'b0;
    evict_d   = 1'b0;
    arm       = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = '0;
    upd_en    = 1'b0;
    upd_alloc = 1'b0;
    if (excl_flush_i) begin
      valid_d = '0;
      pass_d  = (req_cls == REQ_XLD);
      fail_d  = (req_cls == REQ_XST);
    end else begin
      case (req_cls)
        REQ_XLD: begin
          pass_d = 1'b1;
          arm    = 1'b1;
        end
        REQ_XST: begin
          if (st_hit) begin
            pass_d  = 1'b1;
            valid_d = valid_q & ~am_hit;
          end else begin
            fail_d = 1'b1;
            if (is_cu)       arm = 1'b1;
            else if (lp_any) valid_d[lp_idx] = 1'b0;
          end
        end
        REQ_NXW: valid_d = valid_q & ~am_hit;
        default: ;
      endcase
      if (arm) begin
        wr_en  = 1'b1;
        upd_en = 1'b1;
        if (lp_any) begin
          wr_idx = lp_idx;
        end else if (!full) begin
          wr_idx    = free_idx;
          upd_alloc = 1'b1;
        end else begin
          wr_idx  = victim_idx;
          evict_d = 1'b1;
        end
        valid_d[wr_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < N; i++) occ_d = occ_d + OCC_W'(valid_d[i]);
  end

  hnf_mshr_excl_monitor_lru_age #(
    .N     (N),
    .AGE_W (AGE_W)
  ) u_age (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_q),
    .upd_en_i     (upd_en),
    .upd_alloc_i  (upd_alloc),
    .upd_idx_i    (wr_idx),
    .victim_idx_o (victim_idx),
    .full_o       (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      evict_q <= 1'b0;
      occ_q   <= '0;
      for (int i = 0; i < N; i++) begin
        srcid_q[i] <= '0;
        lpid_q[i]  <= '0;
        gaddr_q[i] <= '0;
        ns_q[i]    <= '0;
      end
    end else begin
      valid_q <= valid_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      evict_q <= evict_d;
      occ_q   <= occ_d;
      if (wr_en) begin
        srcid_q[wr_idx] <= li_mshr_rxreq_srcid_s0;
        lpid_q[wr_idx]  <= li_mshr_rxreq_lpid_s0;
        gaddr_q[wr_idx] <= req_gaddr;
        ns_q[wr_idx]    <= li_mshr_rxreq_ns_s0;
      end
    end
  end

  assign excl_pass_s1   = pass_q;
  assign excl_fail_s1   = fail_q;
  assign excl_evict_s1  = evict_q;
  assign excl_occupancy = occ_q;

`ifdef DISPLAY_FATAL
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (req && li_mshr_rxreq_excl_s0[0] &&
          !(is_xld_op(li_mshr_rxreq_opcode_s0) || is_xst_op(li_mshr_rxreq_opcode_s0)))
        $fatal(1, "exclusive request with unsupported opcode %0h", li_mshr_rxreq_opcode_s0);
      for (int i = 0; i < N; i++) begin
        for (int j = i + 1; j < N; j++) begin
          if (valid_q[i] && valid_q[j] && (srcid_q[i] == srcid_q[j]) && (lpid_q[i] == lpid_q[j]))
            $fatal(1, "entries %0d and %0d share the same SrcID/LPID", i, j);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_hnf_mshr_excl_monitor_lru.sv
// Directed scoreboard bench for the exclusive monitor with a 4-entry table.
module tb_hnf_mshr_excl_monitor_lru;

  localparam logic [6:0] RD_NOSNP  = 7'h04;
  localparam logic [6:0] RD_SHARED = 7'h01;
  localparam logic [6:0] CL_UNIQ   = 7'h0B;
  localparam logic [6:0] WR_UQ_F   = 7'h19;
  localparam logic [6:0] WR_NS_P   = 7'h1C;
  localparam logic [6:0] WR_NS_F   = 7'h1D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_en = 1'b0;
  logic        valid = 1'b0;
  logic [10:0] srcid = '0;
  logic [6:0]  opcode = '0;
  logic [51:0] addr = '0;
  logic [0:0]  ns = '0;
  logic [4:0]  lpid = '0;
  logic [0:0]  excl = '0;
  logic        flush = 1'b0;
  logic        pass_o, fail_o, evict_o;
  logic [2:0]  occ_o;

  typedef struct packed {
    logic       pass;
    logic       fail;
    logic       evict;
    logic [2:0] occ;
  } exp_t;

  exp_t  sb [$];
  string sb_name [$];
  int    n_pass = 0;
  int    n_total = 0;

  always #5 clk = ~clk;

  hnf_mshr_excl_monitor_lru #(
    .EXCL_ENTRY_NUM (4),
    .GRANULE_OFFSET (6)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .mshr_alloc_en_s0        (alloc_en),
    .li_mshr_rxreq_valid_s0  (valid),
    .li_mshr_rxreq_srcid_s0  (srcid),
    .li_mshr_rxreq_opcode_s0 (opcode),
    .li_mshr_rxreq_addr_s0   (addr),
    .li_mshr_rxreq_ns_s0     (ns),
    .li_mshr_rxreq_lpid_s0   (lpid),
    .li_mshr_rxreq_excl_s0   (excl),
    .excl_flush_i            (flush),
    .excl_pass_s1            (pass_o),
    .excl_fail_s1            (fail_o),
    .excl_evict_s1           (evict_o),
    .excl_occupancy          (occ_o)
  );

  // Monitor: every issued vector leaves one expected s1 response in the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t  e;
        exp_t  g;
        string nm;
        e  = sb.pop_front();
        nm = sb_name.pop_front();
        g  = '{pass: pass_o, fail: fail_o, evict: evict_o, occ: occ_o};
        n_total++;
        if (g === e) n_pass++;
        else $display("FAIL %s: got pass=%0b fail=%0b evict=%0b occ=%0d, expected pass=%0b fail=%0b evict=%0b occ=%0d",
                      nm, g.pass, g.fail, g.evict, g.occ, e.pass, e.fail, e.evict, e.occ);
      end
    end
  end

  task automatic step(input logic v, input logic al, input logic [10:0] s, input logic [4:0] lp,
                      input logic [6:0] op, input logic [51:0] a, input logic n, input logic ex,
                      input logic fl, input logic r, input logic ep, input logic ef,
                      input logic ee, input logic [2:0] eo, input string nm);
    valid = v; alloc_en = al; srcid = s; lpid = lp; opcode = op; addr = a;
    ns = n; excl = ex; flush = fl; rst = r;
    @(posedge clk);
    sb.push_back('{pass: ep, fail: ef, evict: ee, occ: eo});
    sb_name.push_back(nm);
    #1;
  endtask

  task automatic xld(input logic [10:0] s, input logic [4:0] lp, input logic [51:0] a, input logic n,
                     input logic ee, input logic [2:0] eo, input string nm);
    step(1, 1, s, lp, RD_NOSNP, a, n, 1, 0, 0, 1, 0, ee, eo, nm);
  endtask

  task automatic xst(input logic [6:0] op, input logic [10:0] s, input logic [4:0] lp,
                     input logic [51:0] a, input logic n, input logic ep, input logic ef,
                     input logic [2:0] eo, input string nm);
    step(1, 1, s, lp, op, a, n, 1, 0, 0, ep, ef, 0, eo, nm);
  endtask

  task automatic idle(input logic [2:0] eo, input string nm);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eo, nm);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({pass_o, fail_o, evict_o, occ_o} === 6'b0) n_pass++;
    else $display("FAIL reset_state: got pass=%0b fail=%0b evict=%0b occ=%0d, expected all 0",
                  pass_o, fail_o, evict_o, occ_o);

    xld(1, 0, 52'h1000, 0, 0, 1, "xld_s1");
    xst(WR_NS_F, 1, 0, 52'h1000, 0, 1, 0, 0, "xst_s1_pass");

    xld(1, 0, 52'h1000, 0, 0, 1, "two_xld_s1");
    xld(2, 0, 52'h1000, 0, 0, 2, "two_xld_s2");
    xst(WR_NS_F, 1, 0, 52'h1000, 0, 1, 0, 0, "two_xst_s1_pass");
    xst(WR_NS_F, 2, 0, 52'h1000, 0, 0, 1, 0, "two_xst_s2_fail");

    xld(1, 0, 52'h1000, 0, 0, 1, "nxw_xld");
    step(1, 1, 9, 0, WR_UQ_F, 52'h1020, 0, 0, 0, 0, 0, 0, 0, 0, "nxw_same_ns_clears");
    xst(WR_NS_F, 1, 0, 52'h1000, 0, 0, 1, 0, "nxw_xst_fail");
    xld(1, 0, 52'h1000, 0, 0, 1, "nxw_ns_xld");
    step(1, 1, 9, 0, WR_UQ_F, 52'h1020, 1, 0, 0, 0, 0, 0, 0, 1, "nxw_other_ns_keeps");
    xst(WR_NS_P, 1, 0, 52'h1000, 0, 1, 0, 0, "nxw_ns_xst_pass");

    xld(1, 0, 52'h1000, 0, 0, 1, "lru_fill_s1");
    xld(2, 0, 52'h2000, 0, 0, 2, "lru_fill_s2");
    xld(3, 0, 52'h3000, 0, 0, 3, "lru_fill_s3");
    xld(4, 0, 52'h4000, 0, 0, 4, "lru_fill_s4");
    xld(1, 0, 52'h1000, 0, 0, 4, "lru_touch_s1");
    xld(5, 0, 52'h5000, 0, 1, 4, "lru_evict_s5");
    xst(WR_NS_F, 2, 0, 52'h2000, 0, 0, 1, 4, "lru_s2_gone_fail");
    xst(WR_NS_F, 5, 0, 52'h5000, 0, 1, 0, 3, "lru_s5_pass");
    xst(WR_NS_F, 1, 0, 52'h1000, 0, 1, 0, 2, "lru_s1_kept_pass");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "flush_only");

    xst(CL_UNIQ, 3, 0, 52'h2000, 0, 0, 1, 1, "cu_first_fail_arm");
    xst(CL_UNIQ, 3, 0, 52'h2000, 0, 1, 0, 0, "cu_repeat_pass");

    xld(1, 0, 52'h1000, 0, 0, 1, "flush_xld");
    step(1, 1, 1, 0, WR_NS_F, 52'h1000, 0, 1, 1, 0, 0, 1, 0, 0, "flush_with_xst_fail");
    step(1, 0, 1, 0, RD_NOSNP, 52'h1000, 0, 1, 0, 0, 0, 0, 0, 0, "alloc_en_low_no_pulse");
    step(1, 1, 1, 0, RD_NOSNP, 52'h1000, 0, 1, 1, 0, 1, 0, 0, 0, "flush_with_xld_pass");
    xst(WR_NS_F, 1, 0, 52'h1000, 0, 0, 1, 0, "flush_xld_not_recorded");
    step(1, 1, 1, 0, RD_SHARED, 52'h1000, 0, 0, 0, 0, 0, 0, 0, 0, "other_opcode_ignored");

    xld(6, 0, 52'h6000, 0, 0, 1, "pre_reset_xld");
    step(1, 1, 7, 0, RD_NOSNP, 52'h7000, 0, 1, 0, 1, 0, 0, 0, 0, "reset_drops_pulse");
    xst(WR_NS_F, 6, 0, 52'h6000, 0, 0, 1, 0, "reset_cleared_table");

    xld(1, 1, 52'h3000, 0, 0, 1, "lpid_xld_lp1");
    xst(WR_NS_F, 1, 0, 52'h3000, 0, 0, 1, 1, "lpid_other_lp_fail");
    xst(WR_NS_F, 1, 1, 52'h3000, 0, 1, 0, 0, "lpid_own_lp_pass");

    idle(0, "idle_end");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d pending responses, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
